// File: rtl/line_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_fmt_pkg
// Description : Shared constants, FSM state type and line geometry for the
//               UART line formatter. Line length depends on LINE_FMT_TEMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package line_fmt_pkg;

    // ASCII characters used by the fixed parts of the line
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_X     = 8'h58;
    localparam logic [7:0] ASCII_Y     = 8'h59;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_T     = 8'h54;

    // Byte index width; covers the longest (35 byte) line
    localparam int IDX_W = 6;

`ifdef LINE_FMT_TEMP_EN
    localparam int LINE_LEN = 35;
`else
    localparam int LINE_LEN = 25;
`endif

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_LEN - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Sign character for a field: '-' when negative, otherwise the configured char
    function automatic logic [7:0] sign_char(input logic neg, input logic [7:0] pos_char);
        return neg ? ASCII_MINUS : pos_char;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_char_select.sv
`default_nettype none
// ============================================================================
// Module      : line_char_select
// Description : Maps a byte index plus the latched fields/signs onto the
//               character at that position of the output line. Purely
//               combinational. T field present only with LINE_FMT_TEMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module line_char_select
    import line_fmt_pkg::*;
#(
    parameter logic [7:0] POS_CHAR = 8'h2B,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [3:0][7:0]  x_digits_i,   // [3] is the most significant digit
    input  logic [3:0][7:0]  y_digits_i,
    input  logic [3:0][7:0]  z_digits_i,
    input  logic             neg_x_i,
    input  logic             neg_y_i,
    input  logic             neg_z_i,
`ifdef LINE_FMT_TEMP_EN
    input  logic [5:0][7:0]  t_digits_i,
    input  logic             neg_t_i,
`endif
    output logic [7:0]       char_o
);

    // Position-to-character lookup for the whole line
    always_comb begin
        char_o = 8'h00;
        case (idx_i)
            6'd0:  char_o = ASCII_X;
            6'd1:  char_o = ASCII_EQ;
            6'd2:  char_o = sign_char(neg_x_i, POS_CHAR);
            6'd3:  char_o = x_digits_i[3];
            6'd4:  char_o = x_digits_i[2];
            6'd5:  char_o = x_digits_i[1];
            6'd6:  char_o = x_digits_i[0];
            6'd7:  char_o = SEP_CHAR;
            6'd8:  char_o = ASCII_Y;
            6'd9:  char_o = ASCII_EQ;
            6'd10: char_o = sign_char(neg_y_i, POS_CHAR);
            6'd11: char_o = y_digits_i[3];
            6'd12: char_o = y_digits_i[2];
            6'd13: char_o = y_digits_i[1];
            6'd14: char_o = y_digits_i[0];
            6'd15: char_o = SEP_CHAR;
            6'd16: char_o = ASCII_Z;
            6'd17: char_o = ASCII_EQ;
            6'd18: char_o = sign_char(neg_z_i, POS_CHAR);
            6'd19: char_o = z_digits_i[3];
            6'd20: char_o = z_digits_i[2];
            6'd21: char_o = z_digits_i[1];
            6'd22: char_o = z_digits_i[0];
`ifdef LINE_FMT_TEMP_EN
            6'd23: char_o = SEP_CHAR;
            6'd24: char_o = ASCII_T;
            6'd25: char_o = ASCII_EQ;
            6'd26: char_o = sign_char(neg_t_i, POS_CHAR);
            6'd27: char_o = t_digits_i[5];
            6'd28: char_o = t_digits_i[4];
            6'd29: char_o = t_digits_i[3];
            6'd30: char_o = t_digits_i[2];
            6'd31: char_o = t_digits_i[1];
            6'd32: char_o = t_digits_i[0];
            6'd33: char_o = ASCII_CR;
            6'd34: char_o = ASCII_LF;
`else
            6'd23: char_o = ASCII_CR;
            6'd24: char_o = ASCII_LF;
`endif
            default: char_o = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_line_formatter.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_formatter
// Description : Latches one sample set of ASCII digit fields and signs on a
//               trigger pulse and streams the formatted text line to the UART
//               transmitter over a valid/ready byte handshake. Triggers that
//               arrive while a line is in progress are counted and dropped.
//               Macro LINE_FMT_TEMP_EN adds the T field (35-byte line);
//               without it the line is 25 bytes and the T inputs are unused.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_formatter
    import line_fmt_pkg::*;
#(
    parameter logic [7:0] POS_CHAR   = 8'h2B,
    parameter logic [7:0] SEP_CHAR   = 8'h20,
    parameter int         DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_ready_for_printing_i,
    input  logic [7:0]            ascii_X1_i,
    input  logic [7:0]            ascii_X2_i,
    input  logic [7:0]            ascii_X3_i,
    input  logic [7:0]            ascii_X4_i,
    input  logic [7:0]            ascii_Y1_i,
    input  logic [7:0]            ascii_Y2_i,
    input  logic [7:0]            ascii_Y3_i,
    input  logic [7:0]            ascii_Y4_i,
    input  logic [7:0]            ascii_Z1_i,
    input  logic [7:0]            ascii_Z2_i,
    input  logic [7:0]            ascii_Z3_i,
    input  logic [7:0]            ascii_Z4_i,
    input  logic [7:0]            ascii_T1_i,
    input  logic [7:0]            ascii_T2_i,
    input  logic [7:0]            ascii_T3_i,
    input  logic [7:0]            ascii_T4_i,
    input  logic [7:0]            ascii_T5_i,
    input  logic [7:0]            ascii_T6_i,
    input  logic                  is_negative_X_i,
    input  logic                  is_negative_Y_i,
    input  logic                  is_negative_Z_i,
    input  logic                  is_negative_T_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  line_done_o,
    output logic [DROP_CNT_W-1:0] dropped_count_o
);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  line_done_q, line_done_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  latch_en;

    logic [3:0][7:0]       x_q, y_q, z_q;
    logic                  neg_x_q, neg_y_q, neg_z_q;
    logic [7:0]            w_char;

    // FSM, index, done pulse and drop counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            line_done_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_done_q <= line_done_d;
            drop_q      <= drop_d;
        end
    end

    // Field/sign capture; only loaded when a trigger starts a new line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            neg_x_q <= 1'b0;
            neg_y_q <= 1'b0;
            neg_z_q <= 1'b0;
        end else if (latch_en) begin
            x_q     <= {ascii_X1_i, ascii_X2_i, ascii_X3_i, ascii_X4_i};
            y_q     <= {ascii_Y1_i, ascii_Y2_i, ascii_Y3_i, ascii_Y4_i};
            z_q     <= {ascii_Z1_i, ascii_Z2_i, ascii_Z3_i, ascii_Z4_i};
            neg_x_q <= is_negative_X_i;
            neg_y_q <= is_negative_Y_i;
            neg_z_q <= is_negative_Z_i;
        end
    end

    // Next-state logic: start on trigger in IDLE, advance on each accepted byte,
    // count (saturating) every trigger seen while a line is in progress
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        line_done_d = 1'b0;
        drop_d      = drop_q;
        latch_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_ready_for_printing_i) begin
                    latch_en = 1'b1;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (data_ready_for_printing_i && (drop_q != {DROP_CNT_W{1'b1}})) begin
                    drop_d = drop_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
                end
                if (tx_ready_i) begin
                    if (idx_q == LAST) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        line_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

`ifdef LINE_FMT_TEMP_EN
    logic [5:0][7:0] t_q;
    logic            neg_t_q;

    // T field capture, same timing as the other fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q     <= '0;
            neg_t_q <= 1'b0;
        end else if (latch_en) begin
            t_q     <= {ascii_T1_i, ascii_T2_i, ascii_T3_i, ascii_T4_i, ascii_T5_i, ascii_T6_i};
            neg_t_q <= is_negative_T_i;
        end
    end
`else
    // T inputs stay on the port list for a uniform interface but are not used
    logic w_unused_t;
    assign w_unused_t = ^{ascii_T1_i, ascii_T2_i, ascii_T3_i, ascii_T4_i,
                          ascii_T5_i, ascii_T6_i, is_negative_T_i};
`endif

    line_char_select #(
        .POS_CHAR   (POS_CHAR),
        .SEP_CHAR   (SEP_CHAR)
    ) u_char_select (
        .idx_i      (idx_q),
        .x_digits_i (x_q),
        .y_digits_i (y_q),
        .z_digits_i (z_q),
        .neg_x_i    (neg_x_q),
        .neg_y_i    (neg_y_q),
        .neg_z_i    (neg_z_q),
`ifdef LINE_FMT_TEMP_EN
        .t_digits_i (t_q),
        .neg_t_i    (neg_t_q),
`endif
        .char_o     (w_char)
    );

    // Outputs derive from registered state only, so tx_data is stable while stalled
    assign tx_valid_o      = (state_q == SEND);
    assign busy_o          = (state_q == SEND);
    assign tx_data_o       = (state_q == SEND) ? w_char : 8'h00;
    assign line_done_o     = line_done_q;
    assign dropped_count_o = drop_q;

endmodule
`default_nettype wire
